error_feed: RTL and testbench

- Training-loop stage directly downstream of the perceptron.
- Consumes each perceptron result (8-bit activation) and pairs it with a target label from the training source.
- Computes the signed error `target - result`, scales it, and drives it into the perceptron's 16-bit error input for the weight update.
- Keeps a saturating count of misclassified samples (nonzero error) for epoch monitoring.

---
 rtl/error_feed.sv | 104 ++++++++++
 tb/tb_error_feed.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/error_feed.sv
// Training-loop error stage: pairs a perceptron result with its target label,
// issues the scaled signed error and counts misclassified samples.
module error_feed #(
  parameter int SHIFT = 0,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          arg_stb,
  input  logic [7:0]    arg_dat,
  output logic          arg_rdy,
  input  logic          tgt_stb,
  input  logic [7:0]    tgt_dat,
  output logic          tgt_rdy,
  output logic          err_stb,
  output logic [15:0]   err_dat,
  input  logic          err_rdy,
  output logic [CW-1:0] mis_cnt
);

  typedef enum logic [1:0] {EMPTY, HAVE_ARG, HAVE_TGT, RESP} state_t;

  state_t      state;
  logic [7:0]  arg_q;
  logic [7:0]  tgt_q;
  logic        arg_fire;
  logic        tgt_fire;
  logic        err_fire;
  logic        load;
  logic [7:0]  arg_sel;
  logic [7:0]  tgt_sel;
  logic [8:0]  diff;
  logic [15:0] diff_ext;
  logic [15:0] err_next;
  logic        mis_inc;

  // Ready is combinational on en so a stalled enable never lets a producer
  // believe its word was taken; held low throughout reset.
  always_comb begin
    arg_rdy = 1'b0;
    tgt_rdy = 1'b0;
    if (!rst && en) begin
      arg_rdy = (state == EMPTY) || (state == HAVE_TGT);
      tgt_rdy = (state == EMPTY) || (state == HAVE_ARG);
    end
  end

  // The second half of a pair is taken straight from the port so the error
  // is ready on the same edge that completes the pair.
  always_comb begin
    arg_fire = arg_stb && arg_rdy;
    tgt_fire = tgt_stb && tgt_rdy;
    err_fire = err_stb && err_rdy && en;
    load     = ((state == EMPTY) && arg_fire && tgt_fire) ||
               ((state == HAVE_ARG) && tgt_fire) ||
               ((state == HAVE_TGT) && arg_fire);
    arg_sel  = (state == HAVE_ARG) ? arg_q : arg_dat;
    tgt_sel  = (state == HAVE_TGT) ? tgt_q : tgt_dat;
    diff     = {1'b0, tgt_sel} - {1'b0, arg_sel};
    diff_ext = {{7{diff[8]}}, diff};
    err_next = diff_ext << SHIFT;
    mis_inc  = load && (diff != 9'd0) && (mis_cnt != {CW{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      arg_q   <= 8'd0;
      tgt_q   <= 8'd0;
      err_stb <= 1'b0;
      err_dat <= 16'd0;
      mis_cnt <= '0;
    end else begin
      if (arg_fire)
        arg_q <= arg_dat;
      if (tgt_fire)
        tgt_q <= tgt_dat;
      if (load) begin
        err_dat <= err_next;
        err_stb <= 1'b1;
      end else if (err_fire) begin
        err_stb <= 1'b0;
      end
      if (clr)
        mis_cnt <= '0;
      else if (mis_inc)
        mis_cnt <= mis_cnt + 1'b1;
      case (state)
        EMPTY: begin
          if (arg_fire && tgt_fire) state <= RESP;
          else if (arg_fire)        state <= HAVE_ARG;
          else if (tgt_fire)        state <= HAVE_TGT;
        end
        HAVE_ARG: if (tgt_fire) state <= RESP;
        HAVE_TGT: if (arg_fire) state <= RESP;
        RESP:     if (err_fire) state <= EMPTY;
        default:  state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_error_feed.sv
// Directed bench for error_feed: three instances share stimulus to cover the
// default, SHIFT=7 and CW=2 parameterisations in one run.
module tb_error_feed;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic        arg_stb, tgt_stb, err_rdy;
  logic [7:0]  arg_dat, tgt_dat;

  logic        arg_rdy, tgt_rdy, err_stb;
  logic [15:0] err_dat;
  logic [15:0] mis_cnt;
  logic        s7_arg_rdy, s7_tgt_rdy, s7_err_stb;
  logic [15:0] s7_err_dat;
  logic [15:0] s7_mis_cnt;
  logic        c2_arg_rdy, c2_tgt_rdy, c2_err_stb;
  logic [15:0] c2_err_dat;
  logic [1:0]  c2_mis_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  error_feed #(.SHIFT(0), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(tgt_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
    .mis_cnt(mis_cnt));

  error_feed #(.SHIFT(7), .CW(16)) u_sh7 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(s7_arg_rdy),
    .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(s7_tgt_rdy),
    .err_stb(s7_err_stb), .err_dat(s7_err_dat), .err_rdy(err_rdy),
    .mis_cnt(s7_mis_cnt));

  error_feed #(.SHIFT(0), .CW(2)) u_cw2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(c2_arg_rdy),
    .tgt_stb(tgt_stb), .tgt_dat(tgt_dat), .tgt_rdy(c2_tgt_rdy),
    .err_stb(c2_err_stb), .err_dat(c2_err_dat), .err_rdy(err_rdy),
    .mis_cnt(c2_mis_cnt));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic a_stb, input logic [7:0] a_dat,
                               input logic t_stb, input logic [7:0] t_dat,
                               input logic e_rdy);
    arg_stb = a_stb;
    arg_dat = a_dat;
    tgt_stb = t_stb;
    tgt_dat = t_dat;
    err_rdy = e_rdy;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept the pending error and return the stream to idle.
  task automatic drainError();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1);
    checkOutput("err_stb_after_accept", err_stb, 1'b0);
    err_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(2);
    checkOutput("rst_arg_rdy", arg_rdy, 1'b0);
    checkOutput("rst_tgt_rdy", tgt_rdy, 1'b0);
    checkOutput("rst_err_stb", err_stb, 1'b0);
    checkOutput("rst_err_dat", err_dat, 16'h0000);
    checkOutput("rst_mis_cnt", mis_cnt, 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_arg_rdy", arg_rdy, 1'b1);
    checkOutput("idle_tgt_rdy", tgt_rdy, 1'b1);

    // Both halves in one cycle: 0xFF - 0x00.
    applyStimulus(1'b1, 8'h00, 1'b1, 8'hFF, 1'b0);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t1_err_stb", err_stb, 1'b1);
    checkOutput("t1_err_dat", err_dat, 16'h00FF);
    checkOutput("t1_mis_cnt", mis_cnt, 16'd1);
    checkOutput("t1_sh7_err_dat", s7_err_dat, 16'h7F80);
    checkOutput("t1_resp_arg_rdy", arg_rdy, 1'b0);
    drainError();

    // Arg first, target three cycles later, then a four-cycle stall.
    applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    step(1);
    arg_stb = 1'b0;
    checkOutput("t2_have_arg_arg_rdy", arg_rdy, 1'b0);
    checkOutput("t2_have_arg_tgt_rdy", tgt_rdy, 1'b1);
    checkOutput("t2_have_arg_err_stb", err_stb, 1'b0);
    step(2);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    step(1);
    tgt_stb = 1'b0;
    checkOutput("t2_sh7_err_dat", s7_err_dat, 16'h8080);
    checkOutput("t2_mis_cnt", mis_cnt, 16'd2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_stall_err_stb", err_stb, 1'b1);
      checkOutput("t2_stall_err_dat", err_dat, 16'hFF01);
      checkOutput("t2_stall_arg_rdy", arg_rdy, 1'b0);
      checkOutput("t2_stall_tgt_rdy", tgt_rdy, 1'b0);
      step(1);
    end
    drainError();
    checkOutput("t2_idle_arg_rdy", arg_rdy, 1'b1);

    // Matching pair: zero error, counter untouched.
    applyStimulus(1'b1, 8'h80, 1'b1, 8'h80, 1'b0);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_err_stb", err_stb, 1'b1);
    checkOutput("t3_err_dat", err_dat, 16'h0000);
    checkOutput("t3_sh7_err_dat", s7_err_dat, 16'h0000);
    checkOutput("t3_mis_cnt", mis_cnt, 16'd2);
    checkOutput("t3_cw2_mis_cnt", c2_mis_cnt, 2'd2);
    drainError();

    // Enable dropped in HAVE_ARG while the target is offered.
    applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    step(1);
    en = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h30, 1'b0);
    #1;
    checkOutput("t4_en_low_tgt_rdy", tgt_rdy, 1'b0);
    step(2);
    checkOutput("t4_en_low_err_stb", err_stb, 1'b0);
    checkOutput("t4_en_low_tgt_rdy2", tgt_rdy, 1'b0);
    en = 1'b1;
    #1;
    checkOutput("t4_en_back_tgt_rdy", tgt_rdy, 1'b1);
    step(1);
    tgt_stb = 1'b0;
    checkOutput("t4_err_stb", err_stb, 1'b1);
    checkOutput("t4_err_dat", err_dat, 16'h0020);
    checkOutput("t4_mis_cnt", mis_cnt, 16'd3);
    checkOutput("t4_cw2_mis_cnt", c2_mis_cnt, 2'd3);
    en = 1'b0;
    err_rdy = 1'b1;
    step(1);
    checkOutput("t4_en_low_hold_err_stb", err_stb, 1'b1);
    en = 1'b1;
    drainError();

    // Fourth mismatch saturates the 2-bit counter.
    applyStimulus(1'b1, 8'h05, 1'b1, 8'h01, 1'b0);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_err_dat", err_dat, 16'hFFFC);
    checkOutput("t5_mis_cnt", mis_cnt, 16'd4);
    checkOutput("t5_cw2_sat", c2_mis_cnt, 2'd3);
    drainError();

    // Clear on the same edge as an increment wins.
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h02, 1'b0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t6_clr_mis_cnt", mis_cnt, 16'd0);
    checkOutput("t6_clr_cw2_mis_cnt", c2_mis_cnt, 2'd0);
    checkOutput("t6_err_dat", err_dat, 16'h0001);
    drainError();

    // Clear also acts with enable low.
    applyStimulus(1'b1, 8'h00, 1'b1, 8'h01, 1'b0);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t7_mis_cnt", mis_cnt, 16'd1);
    en  = 1'b0;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    en  = 1'b1;
    checkOutput("t7_clr_en_low", mis_cnt, 16'd0);
    checkOutput("t7_err_stb_held", err_stb, 1'b1);

    // Reset while in RESP with err_rdy high.
    applyStimulus(1'b1, 8'h00, 1'b1, 8'h09, 1'b0);
    err_rdy = 1'b0;
    drainError();
    applyStimulus(1'b1, 8'h00, 1'b1, 8'h09, 1'b0);
    step(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("t8_pre_mis_cnt", mis_cnt, 16'd1);
    err_rdy = 1'b1;
    rst = 1'b1;
    step(1);
    err_rdy = 1'b0;
    checkOutput("t8_rst_err_stb", err_stb, 1'b0);
    checkOutput("t8_rst_mis_cnt", mis_cnt, 16'd0);
    checkOutput("t8_rst_err_dat", err_dat, 16'h0000);
    rst = 1'b0;
    #1;
    checkOutput("t8_empty_arg_rdy", arg_rdy, 1'b1);
    checkOutput("t8_empty_tgt_rdy", tgt_rdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
